// File: rtl/lr35902_dbg_if.sv
// Byte-stream handshake between the debug host link and the LR35902 debug controller.
// The host side is the master: it offers command bytes and accepts response bytes.
interface lr35902_dbg_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/lr35902_dbg_ctrl.sv
// Debug controller for an LR35902 core: halts, resumes, single-steps, injects opcodes
// and reads registers through the probe mux, answering each command with one byte.
module lr35902_dbg_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic                cpu_clk,
    input  logic                reset,
    lr35902_dbg_if.slave        bus,
    input  logic [7:0]          probe,
    output logic [4:0]          probe_sel,
    input  logic                halted,
    output logic                halt,
    output logic                drv,
    output logic [7:0]          data,
    output logic                no_inc,
    output logic                busy
);
    // state  | meaning
    // IDLE   | waiting for an opcode byte
    // ARG    | waiting for the argument byte of READ or EXEC
    // SETTLE | one cycle for the probe mux to follow probe_sel
    // HWAIT  | halt requested, waiting for halted
    // REL    | halt released, waiting for the CPU to leave fetch
    // RWAIT  | halt re-requested, waiting for the CPU to stall again
    // RESP   | presenting the response byte
    typedef enum logic [2:0] {IDLE, ARG, SETTLE, HWAIT, REL, RWAIT, RESP} state_t;

    localparam logic [7:0] OP_HALT = 8'h01;
    localparam logic [7:0] OP_RUN  = 8'h02;
    localparam logic [7:0] OP_STEP = 8'h03;
    localparam logic [7:0] OP_READ = 8'h04;
    localparam logic [7:0] OP_EXEC = 8'h05;
    localparam logic [7:0] RSP_NOT_HALTED = 8'hFD;
    localparam logic [7:0] RSP_TIMEOUT    = 8'hFE;
    localparam logic [7:0] RSP_BAD_OP     = 8'hFF;
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    state_t      state_q;
    logic        halt_q, drv_q, no_inc_q;
    logic [7:0]  data_q, tx_data_q;
    logic [4:0]  probe_sel_q;
    logic [15:0] tmo_q;
    logic        is_exec_q;
    logic        exec_ok_q;

    logic [15:0] tmo_inc;
    logic        tmo_hit;

    assign tmo_inc = tmo_q + 16'd1;
    assign tmo_hit = (tmo_inc == TMO_LIMIT);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            halt_q      <= 1'b0;
            drv_q       <= 1'b0;
            no_inc_q    <= 1'b0;
            data_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            probe_sel_q <= 5'd0;
            tmo_q       <= 16'd0;
            is_exec_q   <= 1'b0;
            exec_ok_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_HALT: begin
                            halt_q  <= 1'b1;
                            tmo_q   <= 16'd0;
                            state_q <= HWAIT;
                        end
                        OP_RUN: begin
                            halt_q    <= 1'b0;
                            tx_data_q <= OP_RUN;
                            state_q   <= RESP;
                        end
                        OP_STEP: begin
                            is_exec_q <= 1'b0;
                            if (halted) begin
                                halt_q  <= 1'b0;
                                tmo_q   <= 16'd0;
                                state_q <= REL;
                            end else begin
                                tx_data_q <= RSP_NOT_HALTED;
                                state_q   <= RESP;
                            end
                        end
                        OP_READ: begin
                            is_exec_q <= 1'b0;
                            state_q   <= ARG;
                        end
                        OP_EXEC: begin
                            is_exec_q <= 1'b1;
                            exec_ok_q <= halted;
                            state_q   <= ARG;
                        end
                        default: begin
                            tx_data_q <= RSP_BAD_OP;
                            state_q   <= RESP;
                        end
                    endcase
                end
                ARG: if (bus.rx_valid) begin
                    if (!is_exec_q) begin
                        probe_sel_q <= bus.rx_data[4:0];
                        state_q     <= SETTLE;
                    end else if (exec_ok_q) begin
                        data_q   <= bus.rx_data;
                        drv_q    <= 1'b1;
                        no_inc_q <= 1'b1;
                        halt_q   <= 1'b0;
                        tmo_q    <= 16'd0;
                        state_q  <= REL;
                    end else begin
                        tx_data_q <= RSP_NOT_HALTED;
                        state_q   <= RESP;
                    end
                end
                SETTLE: begin
                    tx_data_q <= probe;
                    state_q   <= RESP;
                end
                HWAIT, REL, RWAIT: begin
                    tmo_q <= tmo_inc;
                    if (tmo_hit) begin
                        tx_data_q <= RSP_TIMEOUT;
                        halt_q    <= 1'b1;
                        drv_q     <= 1'b0;
                        no_inc_q  <= 1'b0;
                        state_q   <= RESP;
                    end
                    // Exit conditions are assigned last so they override a coincident timeout.
                    case (state_q)
                        HWAIT: if (halted) begin
                            tx_data_q <= OP_HALT;
                            state_q   <= RESP;
                        end
                        REL: if (!halted) begin
                            halt_q   <= 1'b1;
                            drv_q    <= is_exec_q;
                            no_inc_q <= is_exec_q;
                            tmo_q    <= 16'd0;
                            state_q  <= RWAIT;
                        end
                        RWAIT: if (halted) begin
                            halt_q    <= 1'b1;
                            drv_q     <= 1'b0;
                            no_inc_q  <= 1'b0;
                            tx_data_q <= is_exec_q ? OP_EXEC : OP_STEP;
                            state_q   <= RESP;
                        end
                        default: ;
                    endcase
                end
                RESP: if (bus.tx_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_ready = (state_q == IDLE) || (state_q == ARG);
    assign bus.tx_valid = (state_q == RESP);
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state_q != IDLE);
    assign halt         = halt_q;
    assign drv          = drv_q;
    assign no_inc       = no_inc_q;
    assign data         = data_q;
    assign probe_sel    = probe_sel_q;
endmodule

// File: tb/tb_lr35902_dbg_ctrl.sv
// Bench for lr35902_dbg_ctrl: host-side byte driver, response scoreboard and a
// hand-driven CPU halted line with a fixed probe register file.
module tb_lr35902_dbg_ctrl;
    logic       cpu_clk = 1'b0;
    logic       reset;
    logic [7:0] probe;
    logic [4:0] probe_sel;
    logic       halted;
    logic       halt, drv, no_inc, busy;
    logic [7:0] data;

    lr35902_dbg_if bus_if ();

    lr35902_dbg_ctrl #(.TIMEOUT(15)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .bus       (bus_if),
        .probe     (probe),
        .probe_sel (probe_sel),
        .halted    (halted),
        .halt      (halt),
        .drv       (drv),
        .data      (data),
        .no_inc    (no_inc),
        .busy      (busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Register file model: index n reads back 0x50 ^ n.
    assign probe = 8'h50 ^ {3'b000, probe_sel};

    int  n_cmp = 0;
    int  n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (!reset && bus_if.tx_valid && bus_if.tx_ready) begin
            if (exp_q.size() == 0) check("tx_unexpected", 32'(bus_if.tx_data), 32'h100);
            else check("tx_data", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge cpu_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (bus_if.rx_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rx_handshake_timeout", 32'(b), 32'h100);
        tick();
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        halted = 1'b0;
        bus_if.rx_data = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_rx_ready", 32'(bus_if.rx_ready), 1);
        check("rst_halt", 32'(halt), 0);
        check("rst_drv", 32'(drv), 0);
        check("rst_no_inc", 32'(no_inc), 0);
        check("rst_tx_valid", 32'(bus_if.tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(data), 0);
        check("rst_tx_data", 32'(bus_if.tx_data), 0);
        check("rst_probe_sel", 32'(probe_sel), 0);

        // HALT with the CPU stalling 5 cycles later
        exp_q.push_back(8'h01);
        send_byte(8'h01);
        check("halt_set", 32'(halt), 1);
        check("halt_busy", 32'(busy), 1);
        repeat (4) begin
            check("halt_wait_tx_valid", 32'(bus_if.tx_valid), 0);
            tick();
        end
        halted = 1'b1;
        tick();
        check("halt_resp_valid", 32'(bus_if.tx_valid), 1);
        tick();
        check("halt_idle_after_tx", 32'(busy), 0);
        check("halt_persists", 32'(halt), 1);

        // READ register 10, then register 3
        exp_q.push_back(8'h5A);
        send_byte(8'h04);
        send_byte(8'h0A);
        check("read_probe_sel", 32'(probe_sel), 10);
        check("read_settle_tx_valid", 32'(bus_if.tx_valid), 0);
        tick();
        check("read_tx_valid_2cyc", 32'(bus_if.tx_valid), 1);
        wait_idle("read_idle_timeout");
        exp_q.push_back(8'h53);
        send_byte(8'h04);
        send_byte(8'h03);
        wait_idle("read2_idle_timeout");

        // EXEC 0x3C: CPU leaves fetch for 3 cycles
        exp_q.push_back(8'h05);
        send_byte(8'h05);
        send_byte(8'h3C);
        check("exec_rel_halt", 32'(halt), 0);
        check("exec_rel_drv", 32'(drv), 1);
        halted = 1'b0;
        repeat (3) begin
            tick();
            check("exec_drv", 32'(drv), 1);
            check("exec_no_inc", 32'(no_inc), 1);
            check("exec_data", 32'(data), 32'h3C);
            check("exec_rehalt", 32'(halt), 1);
        end
        halted = 1'b1;
        tick();
        check("exec_drv_clr", 32'(drv), 0);
        check("exec_no_inc_clr", 32'(no_inc), 0);
        check("exec_halt_end", 32'(halt), 1);
        check("exec_resp_valid", 32'(bus_if.tx_valid), 1);
        wait_idle("exec_idle_timeout");

        // STEP while halted: no bus drive
        exp_q.push_back(8'h03);
        send_byte(8'h03);
        halted = 1'b0;
        repeat (2) begin
            tick();
            check("step_drv", 32'(drv), 0);
            check("step_no_inc", 32'(no_inc), 0);
        end
        halted = 1'b1;
        wait_idle("step_idle_timeout");

        // HALT with halted stuck low: 15 wait cycles then timeout
        halted = 1'b0;
        exp_q.push_back(8'hFE);
        send_byte(8'h01);
        cnt = 0;
        while (busy && !bus_if.tx_valid && cnt < 100) begin
            cnt++;
            tick();
        end
        check("tmo_wait_cycles", 32'(cnt), 15);
        check("tmo_halt", 32'(halt), 1);
        wait_idle("tmo_idle_timeout");

        // RUN, then STEP/EXEC while running, then an unknown opcode with back-pressure
        exp_q.push_back(8'h02);
        send_byte(8'h02);
        wait_idle("run_idle_timeout");
        check("run_halt_clr", 32'(halt), 0);
        exp_q.push_back(8'hFD);
        send_byte(8'h03);
        cnt = 0;
        while (busy && cnt < 20) begin
            if (halt) cnt = 100;
            else cnt++;
            tick();
        end
        check("step_nh_no_halt", 32'(cnt < 100), 1);
        exp_q.push_back(8'hFD);
        send_byte(8'h05);
        send_byte(8'h11);
        check("exec_nh_drv", 32'(drv), 0);
        wait_idle("exec_nh_idle_timeout");
        bus_if.tx_ready = 1'b0;
        exp_q.push_back(8'hFF);
        send_byte(8'h77);
        exp_q.push_back(8'h02);
        bus_if.rx_data  = 8'h02;
        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hold_tx_valid", 32'(bus_if.tx_valid), 1);
            check("hold_tx_data", 32'(bus_if.tx_data), 32'hFF);
            check("hold_rx_ready", 32'(bus_if.rx_ready), 0);
            tick();
        end
        bus_if.tx_ready = 1'b1;
        send_byte(8'h02);
        wait_idle("bp_idle_timeout");

        // Reset in the middle of EXEC while in RWAIT
        halted = 1'b1;
        send_byte(8'h05);
        send_byte(8'h3C);
        halted = 1'b0;
        tick();
        check("pre_rst_drv", 32'(drv), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_halt", 32'(halt), 0);
        check("mid_rst_drv", 32'(drv), 0);
        check("mid_rst_no_inc", 32'(no_inc), 0);
        check("mid_rst_tx_valid", 32'(bus_if.tx_valid), 0);
        check("mid_rst_rx_ready", 32'(bus_if.rx_ready), 1);
        reset = 1'b0;
        tick();
        check("post_rst_rx_ready", 32'(bus_if.rx_ready), 1);
        check("post_rst_tx_valid", 32'(bus_if.tx_valid), 0);
        repeat (2) tick();

        check("responses_outstanding", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lr35902_dbg_ctrl.md
LR35902_DBG_CTRL -- requirements
Module: lr35902_dbg_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles spent waiting on the halted input before a command is aborted.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: cpu_clk in 1, rising edge, the only clock; reset in 1, synchronous, active-high.
REQ-003 rx_data  in  8  command/argument byte, already in the cpu_clk domain.
REQ-004 rx_valid  in  1; rx_ready  out  1: byte handshake, transfer when both are high.
REQ-005 tx_data  out  8; tx_valid  out  1; tx_ready  in  1: response handshake, transfer when tx_valid and tx_ready are both high.
REQ-006 probe  in  8: content of the register selected by probe_sel, valid one cycle after probe_sel changes.
REQ-007 probe_sel  out  5: register index presented to the CPU probe mux.
REQ-008 halted  in  1: CPU is stalled in its instruction fetch state.
REQ-009 halt  out  1: request CPU stall at instruction fetch.
REQ-010 drv  out  1; data  out  8: drive data on the CPU bus instead of the fetched byte.
REQ-011 no_inc  out  1: suppress PC increment.
REQ-012 busy  out  1: high in every state except IDLE.

Function
REQ-013 The block SHALL have the states IDLE, ARG, SETTLE, HWAIT, REL, RWAIT and RESP.
REQ-014 rx_ready SHALL be 1 only in IDLE and ARG; bytes are accepted only on the handshake.
REQ-015 IDLE, on accepting a byte, SHALL dispatch on opcode: 0x01 HALT, 0x02 RUN, 0x03 STEP, 0x04 READ, 0x05 EXEC; any other value queues response 0xFF and goes to RESP.
REQ-016 HALT SHALL set halt=1 and go to HWAIT; HWAIT exits to RESP with 0x01 on the first cycle with halted=1.
REQ-017 RUN SHALL clear halt on the next edge, then respond 0x02; it SHALL NOT wait on halted.
REQ-018 READ SHALL go to ARG; on the argument handshake, probe_sel <= rx_data[4:0] and the block goes to SETTLE for exactly one cycle.
REQ-019 At the end of SETTLE, READ SHALL capture probe and go to RESP with tx_data=probe, so tx_valid is first high 2 cycles after the argument handshake.
REQ-020 STEP and EXEC SHALL require halted=1 at dispatch; otherwise they respond 0xFD without changing halt, drv or no_inc (for EXEC, the argument byte is still consumed).
REQ-021 STEP: in REL, halt=0 until the first cycle with halted=0; then halt=1 and go to RWAIT; RWAIT exits on halted=1 and responds 0x03.
REQ-022 EXEC: takes its opcode byte in ARG, then runs the STEP sequence with drv=1, no_inc=1 and data=argument throughout REL and RWAIT.
REQ-023 EXEC SHALL clear drv and no_inc on the edge where halted=1 is seen in RWAIT, then respond 0x05.
REQ-024 Timeout: a 16-bit counter SHALL clear on entry to HWAIT, REL or RWAIT and increment each cycle in those states.
REQ-025 When the timeout counter reaches TIMEOUT, the block SHALL respond 0xFE, set halt=1, clear drv and no_inc, and go to RESP.
REQ-026 RESP SHALL hold tx_valid=1 with stable tx_data until tx_ready=1, then return to IDLE on the next edge; tx_valid is 0 in all other states.
REQ-027 Only one command SHALL be in flight at a time; bytes arriving while rx_ready=0 are back-pressured, never dropped.
REQ-028 halt SHALL persist across commands; only RUN, REL or reset clear it.
REQ-029 If halted and the exit condition occur in the same cycle as the timeout, the exit condition SHALL win.

Reset
REQ-030 On reset: state=IDLE; halt, drv, no_inc, tx_valid, busy = 0; data, tx_data, probe_sel = 0; timeout counter = 0.
REQ-031 rx_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset during any state SHALL abort the command with no response emitted and SHALL release the CPU (halt=0).

Verification
REQ-033 Send 0x01 with halted rising 5 cycles later -> halt=1 next edge, tx 0x01 once halted=1, busy low after tx handshake.
REQ-034 Halted; send 0x04,0x0A with probe model returning 0x5A for index 10 -> probe_sel=10, tx_valid 2 cycles after argument, tx_data=0x5A.
REQ-035 Halted; send 0x05,0x3C with CPU model dropping halted for 3 cycles -> drv=1, data=0x3C and no_inc=1 during the step, all cleared when halted returns, tx 0x05, halt=1.
REQ-036 Send 0x01 with halted stuck 0 and TIMEOUT=15 -> tx 0xFE after 15 wait cycles, halt stays 1.
REQ-037 Send 0x03 while not halted -> tx 0xFD, no halt edge; send 0x77 -> tx 0xFF; hold tx_ready=0 for 4 cycles -> tx_data stable and rx_ready=0 throughout.
REQ-038 Assert reset mid-EXEC in RWAIT -> next cycle halt, drv and no_inc = 0, no tx_valid, rx_ready=1.
